instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 The block SHALL have parameter INS_LEN, default 54, giving the instruction word width.
REQ-002 The block SHALL have parameter PF_DEPTH, default 4, giving the prefetch FIFO depth; legal values are powers of two, 2..16.
REQ-003 Port clk, input, 1 bit: clock.
REQ-004 Port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 Port start, input, 1 bit: one-cycle pulse that launches a program.
REQ-006 Port start_pc, input, 10 bits: first instruction address, sampled with start.
REQ-007 Port abort, input, 1 bit: synchronous flush request.
REQ-008 Port icache_rd_ctrl_en, output, 1 bit: instruction cache read enable.
REQ-009 Port icache_rd_ctrl_addr, output, 10 bits: instruction cache read address.
REQ-010 Port icache_rd_ctrl_data, input, INS_LEN bits: cache read data, valid combinationally in the same cycle as the enable.
REQ-011 Port ins_valid, output, 1 bit: instruction available to the decoder.
REQ-012 Port ins_data, output, INS_LEN bits: head instruction.
REQ-013 Port ins_pc, output, 10 bits: address of the head instruction.
REQ-014 Port ins_ready, input, 1 bit: decoder accepts the head instruction.
REQ-015 Port busy, output, 1 bit: high whenever state is not IDLE.
REQ-016 Port done, output, 1 bit: one-cycle pulse at program end.
REQ-017 Port perf_fetch_cnt, output, 32 bits: count of fetched instructions.
REQ-018 Port perf_stall_cnt, output, 32 bits: count of stall cycles.

Function
REQ-019 The FSM SHALL have states IDLE, FETCH, DRAIN and DONE.
REQ-020 IDLE: on start=1, the block SHALL load pc<=start_pc and go to FETCH; start SHALL be ignored in every other state.
REQ-021 FETCH: when count<PF_DEPTH, the block SHALL assert icache_rd_ctrl_en=1 with icache_rd_ctrl_addr=pc and capture icache_rd_ctrl_data in that same cycle.
REQ-022 FETCH, non-HALT word: the block SHALL push {word, pc} into the FIFO and set pc<=pc+1 modulo 1024 (1023 wraps to 0).
REQ-023 HALT is defined as a word whose bits [INS_LEN-1:INS_LEN-4] equal 4'h0; the block SHALL NOT push a HALT word, SHALL hold pc, and SHALL go to DRAIN.
REQ-024 FETCH with count==PF_DEPTH: icache_rd_ctrl_en SHALL be 0 and pc SHALL hold, even if a pop occurs in the same cycle.
REQ-025 In every state other than FETCH, icache_rd_ctrl_en SHALL be 0 and icache_rd_ctrl_addr SHALL equal pc.
REQ-026 ins_valid SHALL equal (count!=0); ins_data and ins_pc SHALL show the FIFO head and SHALL be 0 when the FIFO is empty.
REQ-027 A pop SHALL occur when ins_valid&&ins_ready; a push and a pop in the same cycle SHALL leave count unchanged.
REQ-028 DRAIN: when count reaches 0, including via a pop that cycle, the block SHALL go to DONE.
REQ-029 DONE: done SHALL be 1 for exactly one cycle, then the FSM SHALL go to IDLE.
REQ-030 Latency: with start at cycle T, the first fetch SHALL occur at T+1 and ins_valid SHALL rise at T+2.
REQ-031 abort=1 in any state SHALL clear the FIFO, block push and pop that cycle, and go to IDLE next cycle with no done pulse.
REQ-032 abort SHALL take priority over start.
REQ-033 FIFO ordering SHALL be strict first-in first-out; pointers SHALL wrap at PF_DEPTH.

Reset
REQ-034 While rst=1, the block SHALL set state=IDLE, pc=0, count=0, FIFO pointers=0 and both perf counters=0.
REQ-035 While rst=1, all outputs SHALL be 0.
REQ-036 Reset asserted mid-program SHALL discard all buffered instructions immediately.

Configuration
REQ-037 With macro IFETCH_PERF_CNT_EN defined, perf_fetch_cnt SHALL increment per pushed instruction and perf_stall_cnt SHALL increment per FETCH cycle with count==PF_DEPTH.
REQ-038 With IFETCH_PERF_CNT_EN defined, both counters SHALL clear on start, wrap at 2^32, and ignore abort.
REQ-039 Without IFETCH_PERF_CNT_EN, both perf ports SHALL be tied to 0 and no counter logic SHALL be built.

Verification
REQ-040 Cache 0..2 = non-HALT A,B,C, word 3 = HALT, start_pc=0, ins_ready=1 -> A,B,C out with ins_pc 0,1,2 on consecutive cycles, then done a single pulse, busy low after.
REQ-041 ins_ready=0 for 10 cycles after start, PF_DEPTH=4 -> exactly 4 fetches at addresses 0..3, icache_rd_ctrl_en low afterwards; with the macro, perf_stall_cnt counts each blocked cycle.
REQ-042 start_pc=1022, non-HALT words at 1022, 1023 and 0, HALT at 1 -> ins_pc sequence 1022, 1023, 0, then done.
REQ-043 abort asserted with 3 instructions buffered -> ins_valid=0 next cycle, state IDLE, no done pulse; a later start runs normally.
REQ-044 start pulsed while busy -> ignored, pc and outputs unaffected.
REQ-045 rst asserted mid-FETCH -> all outputs 0 immediately, asynchronously, without waiting for a clock edge.

Source files
------------

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: reads the instruction cache into a small prefetch FIFO until a HALT word is seen.
// Optional performance counters are built only when IFETCH_PERF_CNT_EN is defined.
module instruction_fetch #(
    parameter int INS_LEN  = 54,
    parameter int PF_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [9:0]         start_pc,
    input  logic               abort,
    output logic               icache_rd_ctrl_en,
    output logic [9:0]         icache_rd_ctrl_addr,
    input  logic [INS_LEN-1:0] icache_rd_ctrl_data,
    output logic               ins_valid,
    output logic [INS_LEN-1:0] ins_data,
    output logic [9:0]         ins_pc,
    input  logic               ins_ready,
    output logic               busy,
    output logic               done,
    output logic [31:0]        perf_fetch_cnt,
    output logic [31:0]        perf_stall_cnt
);

    localparam int PTR_W = (PF_DEPTH > 1) ? $clog2(PF_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(PF_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        DONE
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [9:0]         pc;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   count_next;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [INS_LEN+9:0] fifo_mem [PF_DEPTH];

    logic start_accept;
    logic fetch_en;
    logic word_is_halt;
    logic push;
    logic pop;
    logic stall;

    assign start_accept = (state == IDLE) && start && !abort;
    assign fetch_en     = (state == FETCH) && (count < DEPTH_C);
    assign word_is_halt = (icache_rd_ctrl_data[INS_LEN-1 -: 4] == 4'h0);
    assign push         = fetch_en && !word_is_halt && !abort;
    assign pop          = ins_valid && ins_ready && !abort;
    assign stall        = (state == FETCH) && (count == DEPTH_C);

    assign icache_rd_ctrl_en   = fetch_en;
    assign icache_rd_ctrl_addr = pc;

    // FIFO entries carry {word, pc}; the head is masked to zero while empty.
    assign ins_valid = (count != '0);
    assign ins_data  = ins_valid ? fifo_mem[rd_ptr][INS_LEN+9:10] : '0;
    assign ins_pc    = ins_valid ? fifo_mem[rd_ptr][9:0] : '0;

    assign busy = (state != IDLE);
    assign done = (state == DONE) && !abort;

    always_comb begin
        count_next = count;
        if (abort) begin
            count_next = '0;
        end else if (push && !pop) begin
            count_next = count + CNT_W'(1);
        end else if (!push && pop) begin
            count_next = count - CNT_W'(1);
        end
    end

    // DRAIN leaves as soon as the last buffered word is accepted, even in the same cycle.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (start_accept) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (fetch_en && word_is_halt) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (count_next == '0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            pc     <= '0;
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
            if (start_accept) begin
                pc <= start_pc;
            end else if (push) begin
                pc <= pc + 10'd1;
            end
            if (abort) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {icache_rd_ctrl_data, pc};
        end
    end

`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] stall_cnt_q;

    // Counters restart with each program and deliberately ignore abort.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else if (start_accept) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (push) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if (stall) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
`else
    logic unused_stall;
    assign unused_stall   = stall;
    assign perf_fetch_cnt = '0;
    assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed testbench for instruction_fetch with a combinational cache model.
module tb_instruction_fetch;

    logic        clk;
    logic        rst;
    logic        start;
    logic [9:0]  start_pc;
    logic        abort;
    logic        icache_rd_ctrl_en;
    logic [9:0]  icache_rd_ctrl_addr;
    logic [53:0] icache_rd_ctrl_data;
    logic        ins_valid;
    logic [53:0] ins_data;
    logic [9:0]  ins_pc;
    logic        ins_ready;
    logic        busy;
    logic        done;
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;

    logic [53:0] cache_mem [1024];
    logic [53:0] halt_word;
    int          checks;
    int          errors;

    instruction_fetch #(
        .INS_LEN (54),
        .PF_DEPTH(4)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .start              (start),
        .start_pc           (start_pc),
        .abort              (abort),
        .icache_rd_ctrl_en  (icache_rd_ctrl_en),
        .icache_rd_ctrl_addr(icache_rd_ctrl_addr),
        .icache_rd_ctrl_data(icache_rd_ctrl_data),
        .ins_valid          (ins_valid),
        .ins_data           (ins_data),
        .ins_pc             (ins_pc),
        .ins_ready          (ins_ready),
        .busy               (busy),
        .done               (done),
        .perf_fetch_cnt     (perf_fetch_cnt),
        .perf_stall_cnt     (perf_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb icache_rd_ctrl_data = cache_mem[icache_rd_ctrl_addr];

    function automatic logic [53:0] mkWord(input logic [3:0] op, input logic [9:0] tag);
        return {op, 40'h0, tag};
    endfunction

    task automatic applyStimulus(input logic s, input logic [9:0] spc, input logic a, input logic r);
        @(negedge clk);
        start     = s;
        start_pc  = spc;
        abort     = a;
        ins_ready = r;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_en"}, 64'(icache_rd_ctrl_en), 64'd0);
        checkOutput({tag, "_addr"}, 64'(icache_rd_ctrl_addr), 64'd0);
        checkOutput({tag, "_valid"}, 64'(ins_valid), 64'd0);
        checkOutput({tag, "_data"}, 64'(ins_data), 64'd0);
        checkOutput({tag, "_pc"}, 64'(ins_pc), 64'd0);
        checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
        checkOutput({tag, "_done"}, 64'(done), 64'd0);
        checkOutput({tag, "_pfetch"}, 64'(perf_fetch_cnt), 64'd0);
        checkOutput({tag, "_pstall"}, 64'(perf_stall_cnt), 64'd0);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        start     = 1'b0;
        start_pc  = '0;
        abort     = 1'b0;
        ins_ready = 1'b0;
        halt_word = mkWord(4'h0, 10'h3FF);
        for (int i = 0; i < 1024; i++) cache_mem[i] = halt_word;

        repeat (2) @(posedge clk);
        #2;
        checkAllZero("reset");
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] basic program A,B,C,HALT");
        cache_mem[0] = mkWord(4'h1, 10'd10);
        cache_mem[1] = mkWord(4'h1, 10'd11);
        cache_mem[2] = mkWord(4'h1, 10'd12);
        cache_mem[3] = halt_word;
        applyStimulus(1, 10'd0, 0, 1);
        checkOutput("t1_busy_start", 64'(busy), 64'd0);
        applyStimulus(0, 10'd0, 0, 1);
        checkOutput("t1_en_first", 64'(icache_rd_ctrl_en), 64'd1);
        checkOutput("t1_addr_first", 64'(icache_rd_ctrl_addr), 64'd0);
        checkOutput("t1_valid_first", 64'(ins_valid), 64'd0);
        checkOutput("t1_busy", 64'(busy), 64'd1);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 10'd0, 0, 1);
            checkOutput("t1_valid", 64'(ins_valid), 64'd1);
            checkOutput("t1_pc", 64'(ins_pc), 64'(k));
            checkOutput("t1_data", 64'(ins_data), 64'(mkWord(4'h1, 10'(10 + k))));
            checkOutput("t1_addr", 64'(icache_rd_ctrl_addr), 64'(k + 1));
        end
        applyStimulus(0, 10'd0, 0, 1);
        checkOutput("t1_drain_valid", 64'(ins_valid), 64'd0);
        checkOutput("t1_drain_en", 64'(icache_rd_ctrl_en), 64'd0);
        checkOutput("t1_drain_done", 64'(done), 64'd0);
        applyStimulus(0, 10'd0, 0, 1);
        checkOutput("t1_done", 64'(done), 64'd1);
        applyStimulus(0, 10'd0, 0, 1);
        checkOutput("t1_done_after", 64'(done), 64'd0);
        checkOutput("t1_busy_after", 64'(busy), 64'd0);
`ifdef IFETCH_PERF_CNT_EN
        checkOutput("t1_pfetch", 64'(perf_fetch_cnt), 64'd3);
        checkOutput("t1_pstall", 64'(perf_stall_cnt), 64'd0);
`else
        checkOutput("t1_pfetch", 64'(perf_fetch_cnt), 64'd0);
        checkOutput("t1_pstall", 64'(perf_stall_cnt), 64'd0);
`endif

        $display("[TB] backpressure fills prefetch FIFO");
        for (int i = 0; i < 6; i++) cache_mem[i] = mkWord(4'h2, 10'(i));
        cache_mem[6] = halt_word;
        applyStimulus(1, 10'd0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(0, 10'd0, 0, 0);
            checkOutput("t2_fill_en", 64'(icache_rd_ctrl_en), 64'd1);
            checkOutput("t2_fill_addr", 64'(icache_rd_ctrl_addr), 64'(k));
        end
        for (int k = 0; k < 6; k++) begin
            applyStimulus(0, 10'd0, 0, 0);
            checkOutput("t2_full_en", 64'(icache_rd_ctrl_en), 64'd0);
            checkOutput("t2_full_pc", 64'(ins_pc), 64'd0);
        end
`ifdef IFETCH_PERF_CNT_EN
        checkOutput("t2_pstall_mid", 64'(perf_stall_cnt), 64'd5);
`endif
        for (int k = 0; k < 6; k++) begin
            applyStimulus(0, 10'd0, 0, 1);
            checkOutput("t2_pc", 64'(ins_pc), 64'(k));
            checkOutput("t2_data", 64'(ins_data), 64'(mkWord(4'h2, 10'(k))));
        end
        applyStimulus(0, 10'd0, 0, 1);
        checkOutput("t2_done", 64'(done), 64'd1);
`ifdef IFETCH_PERF_CNT_EN
        checkOutput("t2_pfetch", 64'(perf_fetch_cnt), 64'd6);
        checkOutput("t2_pstall", 64'(perf_stall_cnt), 64'd7);
`endif
        applyStimulus(0, 10'd0, 0, 1);
        checkOutput("t2_busy_after", 64'(busy), 64'd0);

        $display("[TB] pc wrap 1022 -> 0");
        cache_mem[1022] = mkWord(4'h3, 10'd1);
        cache_mem[1023] = mkWord(4'h3, 10'd2);
        cache_mem[0]    = mkWord(4'h3, 10'd3);
        cache_mem[1]    = halt_word;
        applyStimulus(1, 10'd1022, 0, 1);
        applyStimulus(0, 10'd0, 0, 1);
        checkOutput("t3_addr_first", 64'(icache_rd_ctrl_addr), 64'd1022);
        applyStimulus(0, 10'd0, 0, 1);
        checkOutput("t3_pc0", 64'(ins_pc), 64'd1022);
        checkOutput("t3_data0", 64'(ins_data), 64'(mkWord(4'h3, 10'd1)));
        applyStimulus(0, 10'd0, 0, 1);
        checkOutput("t3_pc1", 64'(ins_pc), 64'd1023);
        applyStimulus(0, 10'd0, 0, 1);
        checkOutput("t3_pc2", 64'(ins_pc), 64'd0);
        checkOutput("t3_data2", 64'(ins_data), 64'(mkWord(4'h3, 10'd3)));
        checkOutput("t3_addr_halt", 64'(icache_rd_ctrl_addr), 64'd1);
        applyStimulus(0, 10'd0, 0, 1);
        checkOutput("t3_drain_valid", 64'(ins_valid), 64'd0);
        applyStimulus(0, 10'd0, 0, 1);
        checkOutput("t3_done", 64'(done), 64'd1);
        applyStimulus(0, 10'd0, 0, 1);

        $display("[TB] start while busy, then abort");
        for (int i = 0; i < 6; i++) cache_mem[i] = mkWord(4'h4, 10'(i));
        cache_mem[6] = halt_word;
        applyStimulus(1, 10'd0, 0, 0);
        applyStimulus(0, 10'd0, 0, 0);
        checkOutput("t4_addr0", 64'(icache_rd_ctrl_addr), 64'd0);
        applyStimulus(1, 10'd500, 0, 0);
        checkOutput("t4_addr1_restart", 64'(icache_rd_ctrl_addr), 64'd1);
        applyStimulus(0, 10'd0, 0, 0);
        checkOutput("t4_addr2_ignored", 64'(icache_rd_ctrl_addr), 64'd2);
        checkOutput("t4_head_pc", 64'(ins_pc), 64'd0);
        applyStimulus(0, 10'd0, 1, 0);
        checkOutput("t4_valid_pre_abort", 64'(ins_valid), 64'd1);
        checkOutput("t4_done_abort", 64'(done), 64'd0);
        applyStimulus(0, 10'd0, 0, 0);
        checkOutput("t4_valid_post", 64'(ins_valid), 64'd0);
        checkOutput("t4_data_post", 64'(ins_data), 64'd0);
        checkOutput("t4_busy_post", 64'(busy), 64'd0);
        checkOutput("t4_en_post", 64'(icache_rd_ctrl_en), 64'd0);
        checkOutput("t4_done_post", 64'(done), 64'd0);
        applyStimulus(0, 10'd0, 0, 0);
        checkOutput("t4_done_post2", 64'(done), 64'd0);
        applyStimulus(1, 10'd0, 1, 0);
        applyStimulus(0, 10'd0, 0, 0);
        checkOutput("t4_abort_beats_start", 64'(busy), 64'd0);

        applyStimulus(1, 10'd0, 0, 1);
        applyStimulus(0, 10'd0, 0, 1);
        checkOutput("t4_rerun_addr0", 64'(icache_rd_ctrl_addr), 64'd0);
        for (int k = 0; k < 6; k++) begin
            applyStimulus(0, 10'd0, 0, 1);
            checkOutput("t4_rerun_pc", 64'(ins_pc), 64'(k));
            checkOutput("t4_rerun_data", 64'(ins_data), 64'(mkWord(4'h4, 10'(k))));
        end
        applyStimulus(0, 10'd0, 0, 1);
        checkOutput("t4_rerun_drain_done", 64'(done), 64'd0);
        applyStimulus(0, 10'd0, 0, 1);
        checkOutput("t4_rerun_done", 64'(done), 64'd1);
        applyStimulus(0, 10'd0, 0, 1);

        $display("[TB] asynchronous reset mid-fetch");
        applyStimulus(1, 10'd0, 0, 0);
        applyStimulus(0, 10'd0, 0, 0);
        applyStimulus(0, 10'd0, 0, 0);
        applyStimulus(0, 10'd0, 0, 0);
        checkOutput("t5_en_before", 64'(icache_rd_ctrl_en), 64'd1);
        checkOutput("t5_valid_before", 64'(ins_valid), 64'd1);
        #1;
        rst = 1'b1;
        #1;
        checkAllZero("t5_async");
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(0, 10'd0, 0, 1);
        checkOutput("t5_valid_after", 64'(ins_valid), 64'd0);
        checkOutput("t5_busy_after", 64'(busy), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
